// File: rtl/cdc_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_cmd_pkg
//  Brief    : Shared opcodes, response codes and parser states for the CDC
//             command responder.
//  Revision : 1.0 - initial release
// ============================================================================
package cdc_cmd_pkg;

  // Host opcodes (ASCII)
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_ID    = 8'h3F;  // '?'

  // Response bytes
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  // Address of the read-only GPIO input port in the register map
  localparam logic [3:0] GPIO_IN_ADDR = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cdc_cmd_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_cmd_responder_if
//  Brief    : CDC bulk byte streams (OUT: host->app, IN: app->host), each a
//             valid/ready handshake. master = USB CDC side, slave = responder.
//  Revision : 1.0 - initial release
// ============================================================================
interface cdc_cmd_responder_if;
  logic [7:0] out_data_i;
  logic       out_valid_i;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i;

  modport master (
    output out_data_i, out_valid_i, in_ready_i,
    input  out_ready_o, in_data_o, in_valid_o
  );

  modport slave (
    input  out_data_i, out_valid_i, in_ready_i,
    output out_ready_o, in_data_o, in_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/cmd_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_resp_fifo
//  Brief    : First-word-fallthrough synchronous FIFO with synchronous flush.
//             DEPTH must be a power of two, at least 2. Pointers carry one
//             extra wrap bit to distinguish full from empty.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_flush,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_push_data,
  input  wire logic             i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [WIDTH-1:0]      o_rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees a slot on the same edge, so push is allowed at full if popping
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head word is presented combinationally; forced to zero while empty
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array write port (no reset needed: read is masked while empty)
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/cdc_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_cmd_responder
//  Brief    : Parses W<addr><data> / R<addr> / ? commands from the CDC OUT
//             stream against a 16 x 8 register file and returns one response
//             byte per command on the CDC IN stream via a response FIFO.
//             Register 0x0 drives gpio_o; address 0xF reads gpio_i.
//  Options  : CMD_TIMEOUT_EN - abandon a partial command after
//             TIMEOUT_CYCLES idle cycles and answer NAK.
//  Revision : 1.0 - initial release
// ============================================================================
module cdc_cmd_responder
  import cdc_cmd_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [7:0]  ID_BYTE        = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              configured_i,
  cdc_cmd_responder_if.slave     bus,
  input  wire logic [7:0]        gpio_i,
  output logic [7:0]             gpio_o
);

  state_t     r_state;
  logic [7:0] r_addr;
  logic       r_is_wr;
  logic [7:0] r_regs [16];

  logic       w_full;
  logic       w_empty;
  logic       w_acc;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_wr_ok;
  logic       w_tmo_push;

  assign bus.out_ready_o = configured_i && !w_full;
  assign w_acc           = bus.out_valid_i && bus.out_ready_o;
  assign gpio_o          = r_regs[0];

  // Writes land only in the low page and never on the read-only GPIO input
  assign w_wr_ok = (r_addr[7:4] == 4'h0) && (r_addr[3:0] != GPIO_IN_ADDR);

`ifdef CMD_TIMEOUT_EN
  logic [23:0] r_tmo;
  logic        w_tmo_hit;

  assign w_tmo_hit  = (r_state != IDLE) && (r_tmo == TIMEOUT_CYCLES - 24'd1);
  // An accepted byte restarts the wait, so it beats an expiring timer
  assign w_tmo_push = configured_i && w_tmo_hit && !w_acc && !w_full;
`else
  assign w_tmo_push = 1'b0;
`endif

  // Response byte selection for the edge that completes a command
  always_comb begin
    w_push      = 1'b0;
    w_push_data = RSP_NAK;
    if (w_acc) begin
      case (r_state)
        IDLE: begin
          if (bus.out_data_i == OP_ID) begin
            w_push      = 1'b1;
            w_push_data = ID_BYTE;
          end else if (bus.out_data_i != OP_WRITE && bus.out_data_i != OP_READ) begin
            w_push      = 1'b1;
            w_push_data = RSP_NAK;
          end
        end
        GET_ADDR: begin
          if (!r_is_wr) begin
            w_push = 1'b1;
            if (bus.out_data_i[7:4] != 4'h0)
              w_push_data = RSP_NAK;
            else if (bus.out_data_i[3:0] == GPIO_IN_ADDR)
              w_push_data = gpio_i;
            else
              w_push_data = r_regs[bus.out_data_i[3:0]];
          end
        end
        GET_DATA: begin
          w_push      = 1'b1;
          w_push_data = w_wr_ok ? RSP_ACK : RSP_NAK;
        end
        default: begin
          w_push      = 1'b0;
          w_push_data = RSP_NAK;
        end
      endcase
    end else if (w_tmo_push) begin
      w_push      = 1'b1;
      w_push_data = RSP_NAK;
    end
  end

  // Command parser, register file and optional idle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_is_wr <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
`ifdef CMD_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else if (!configured_i) begin
      r_state <= IDLE;
`ifdef CMD_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      if (w_acc) begin
        case (r_state)
          IDLE: begin
            if (bus.out_data_i == OP_WRITE) begin
              r_state <= GET_ADDR;
              r_is_wr <= 1'b1;
            end else if (bus.out_data_i == OP_READ) begin
              r_state <= GET_ADDR;
              r_is_wr <= 1'b0;
            end
          end
          GET_ADDR: begin
            r_addr  <= bus.out_data_i;
            r_state <= r_is_wr ? GET_DATA : IDLE;
          end
          GET_DATA: begin
            if (w_wr_ok) r_regs[r_addr[3:0]] <= bus.out_data_i;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
`ifdef CMD_TIMEOUT_EN
      if (w_acc || r_state == IDLE) begin
        r_tmo <= '0;
      end else if (w_tmo_hit) begin
        // Hold at the limit until the NAK can be queued
        if (!w_full) begin
          r_state <= IDLE;
          r_tmo   <= '0;
        end
      end else begin
        r_tmo <= r_tmo + 24'd1;
      end
`endif
    end
  end

  cmd_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (!configured_i),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (bus.in_ready_i),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_rd_data   (bus.in_data_o)
  );

  assign bus.in_valid_o = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_cdc_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_cmd_responder
//  Brief    : Directed self-checking bench for cdc_cmd_responder.
//             Define CMD_TIMEOUT_EN to include the idle-timeout scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_cmd_responder;

  logic       clk;
  logic       rst_n;
  logic       configured_i;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;

  cdc_cmd_responder_if bus ();

  cdc_cmd_responder #(
    .FIFO_DEPTH     (4),
    .ID_BYTE        (8'hA5),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .configured_i (configured_i),
    .bus          (bus.slave),
    .gpio_i       (gpio_i),
    .gpio_o       (gpio_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Backpressure-phase monitor
  logic mon_en = 1'b0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;
  int   bad_data = 0;
  int   max_occ = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accepted bytes / delivered responses while enabled
  always @(posedge clk) begin
    if (mon_en) begin
      if (bus.out_valid_i && bus.out_ready_o) acc_cnt++;
      if (bus.in_valid_o && bus.in_ready_i) begin
        pop_cnt++;
        if (bus.in_data_o != 8'hA5) bad_data++;
      end
      if (acc_cnt - pop_cnt > max_occ) max_occ = acc_cnt - pop_cnt;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and hold it until the responder accepts it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.out_data_i  = b;
    bus.out_valid_i = 1'b1;
    while (!bus.out_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.out_valid_i = 1'b0;
  endtask

  // Wait for a response byte, compare it, then pop it
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    while (!bus.in_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_vld"}, 32'(bus.in_valid_o), 32'd1);
    check_eq(tag, 32'(bus.in_data_o), 32'(exp));
    bus.in_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.in_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    configured_i    = 1'b0;
    gpio_i          = 8'h00;
    bus.out_data_i  = 8'h00;
    bus.out_valid_i = 1'b0;
    bus.in_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_ready", 32'(bus.out_ready_o), 32'd0);
    check_eq("rst_in_valid",  32'(bus.in_valid_o),  32'd0);
    check_eq("rst_in_data",   32'(bus.in_data_o),   32'd0);
    check_eq("rst_gpio_o",    32'(gpio_o),          32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    configured_i = 1'b1;
    #1 check_eq("cfg_out_ready", 32'(bus.out_ready_o), 32'd1);

    // Write then read back, then write register 0 to reach gpio_o
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hC3);
    recv_byte("wr3_ack", 8'h06);
    send_byte(8'h52); send_byte(8'h03);
    recv_byte("rd3", 8'hC3);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h5A);
    check_eq("gpio_o_5a", 32'(gpio_o), 32'h5A);
    recv_byte("wr0_ack", 8'h06);

    // Bad address, read-only address, GPIO read, unknown opcode, identify
    send_byte(8'h52); send_byte(8'h13);
    recv_byte("rd_badaddr", 8'h15);
    send_byte(8'h57); send_byte(8'h0F); send_byte(8'h11);
    recv_byte("wr_f_nak", 8'h15);
    gpio_i = 8'h3C;
    send_byte(8'h52); send_byte(8'h0F);
    recv_byte("rd_gpio_in", 8'h3C);
    send_byte(8'h52); send_byte(8'h03);
    recv_byte("rd3_again", 8'hC3);
    send_byte(8'h41);
    recv_byte("unknown_op", 8'h15);
    send_byte(8'h3F);
    recv_byte("ident", 8'hA5);

    // Backpressure: fill the FIFO, then pop and push on the same edges
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h3F);
    @(negedge clk);
    check_eq("full_out_ready", 32'(bus.out_ready_o), 32'd0);
    bus.out_data_i  = 8'h3F;
    bus.out_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("full_still_blocked", 32'(bus.out_ready_o), 32'd0);
    check_eq("full_in_valid",      32'(bus.in_valid_o),  32'd1);
    check_eq("full_in_data",       32'(bus.in_data_o),   32'hA5);
    bus.in_ready_i = 1'b1;
    #1 check_eq("full_pop_same_cyc", 32'(bus.out_ready_o), 32'd0);
    @(posedge clk);
    #1 check_eq("after_pop_ready", 32'(bus.out_ready_o), 32'd1);
    @(posedge clk);
    #1 bus.out_valid_i = 1'b0;
    send_byte(8'h3F);
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    bus.in_ready_i = 1'b0;
    check_eq("bp_accepted", 32'(acc_cnt),  32'd6);
    check_eq("bp_delivered", 32'(pop_cnt), 32'd6);
    check_eq("bp_bad_data", 32'(bad_data), 32'd0);
    check_eq("bp_max_occ",  32'(max_occ),  32'd4);
    check_eq("bp_drained",  32'(bus.in_valid_o), 32'd0);

    // Deconfigure mid-command: flush queued response, return FSM to IDLE
    send_byte(8'h3F);
    send_byte(8'h57); send_byte(8'h02);
    @(negedge clk);
    configured_i = 1'b0;
    #1 check_eq("decfg_out_ready", 32'(bus.out_ready_o), 32'd0);
    @(negedge clk);
    configured_i = 1'b1;
    #1 check_eq("decfg_flushed", 32'(bus.in_valid_o), 32'd0);
    send_byte(8'h52); send_byte(8'h02);
    recv_byte("decfg_rd2", 8'h00);

`ifdef CMD_TIMEOUT_EN
    // Partial read command abandoned after 16 idle cycles
    send_byte(8'h52);
    repeat (15) @(posedge clk);
    #1 check_eq("tmo_early", 32'(bus.in_valid_o), 32'd0);
    @(posedge clk);
    #1 check_eq("tmo_fire", 32'(bus.in_valid_o), 32'd1);
    recv_byte("tmo_nak", 8'h15);
    send_byte(8'h3F);
    recv_byte("tmo_next_id", 8'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
